// File: rtl/pc_sequencer_pkg.sv
// Shared codes for the PC sequencer: next-PC source selector, CALL/RET function codes, opcodes.
// No logic beyond constants; consumed by pc_sequencer and pc_ras.
// Opcode values mirror the datapath's opcode table.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      PCSRC_SEQ = 2'b00,
      PCSRC_JMP = 2'b01,
      PCSRC_BR  = 2'b10,
      PCSRC_REG = 2'b11
   } pc_src_e;

   localparam logic [2:0] FUNC_CALL = 3'b001;
   localparam logic [2:0] FUNC_RET  = 3'b010;

   localparam logic [3:0] OP_RTYPE = 4'b0000;
   localparam logic [3:0] OP_ANDI  = 4'b0001;
   localparam logic [3:0] OP_ADDI  = 4'b0010;
   localparam logic [3:0] OP_LW    = 4'b0011;
   localparam logic [3:0] OP_SW    = 4'b0100;
   localparam logic [3:0] OP_FOR   = 4'b0101;
   localparam logic [3:0] OP_BEQ   = 4'b0110;
   localparam logic [3:0] OP_BNE   = 4'b0111;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer, push overwrites oldest when full; sticky {overflow, underflow}.
// Latency: push/pop take effect at the next clock edge; top is read combinationally.
// Backpressure: none; caller gates push/pop with its own stall.
module pc_ras
   import pc_sequencer_pkg::*;
#(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_dat,
   output logic [W-1:0] top,
   output logic         empty,
   output logic         full,
   output logic [1:0]   err
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [PW-1:0] PONE = PW'(1);
   localparam logic [CW-1:0] CONE = CW'(1);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wp;
   logic [CW-1:0] cnt;

   assign empty = (cnt == '0);
   assign full  = (cnt == CW'(DEPTH));
   assign top   = mem[wp - PONE];

   always_ff @(posedge clk) begin
      if (push && !reset)
         mem[wp] <= push_dat;
   end

   // wp always names the next slot to write, so a push when full lands on the oldest entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         wp  <= '0;
         cnt <= '0;
         err <= '0;
      end else if (push) begin
         wp <= wp + PONE;
         if (full)
            err[1] <= 1'b1;
         else
            cnt <= cnt + CONE;
      end else if (pop) begin
         if (empty) begin
            err[0] <= 1'b1;
         end else begin
            wp  <= wp - PONE;
            cnt <= cnt - CONE;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter unit: next-PC select (seq/jump/branch/reg-return), flush, optional RAS under PC_SEQ_RAS_EN.
// Latency: pc_src/flush combinational from the resolving instruction; new PC on pc_out after one edge.
// Backpressure: stall holds PC and RAS and suppresses flush.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int              PC_W      = 16,
   parameter int              OP_W      = 4,
   parameter int              FUNC_W    = 3,
   parameter int              RAS_DEPTH = 4,
   parameter logic [PC_W-1:0] RESET_PC  = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              rs_valid,
   input  logic [OP_W-1:0]   op,
   input  logic [FUNC_W-1:0] func,
   input  logic              zero,
   input  logic [PC_W-1:0]   rs_pc,
   input  logic [PC_W-1:0]   branch_target,
   input  logic [PC_W-1:0]   jump_target,
   input  logic [PC_W-1:0]   reg_target,
   output logic [PC_W-1:0]   pc_out,
   output logic [1:0]        pc_src,
   output logic              flush,
   output logic              ras_empty,
   output logic              ras_full,
   output logic [1:0]        ras_err
);

   pc_src_e         src;
   logic [PC_W-1:0] reg_pc;
   logic [PC_W-1:0] pc_nxt;

   always_comb begin
      src = PCSRC_SEQ;
      if (rs_valid) begin
         case (op)
            OP_W'(OP_BEQ):   src = zero ? PCSRC_BR : PCSRC_SEQ;
            OP_W'(OP_BNE):   src = zero ? PCSRC_SEQ : PCSRC_BR;
            OP_W'(OP_RTYPE),
            OP_W'(OP_ANDI),
            OP_W'(OP_ADDI),
            OP_W'(OP_LW),
            OP_W'(OP_SW),
            OP_W'(OP_FOR):   src = PCSRC_SEQ;
            default:         src = (func == FUNC_W'(FUNC_RET)) ? PCSRC_REG : PCSRC_JMP;
         endcase
      end
   end

   assign pc_src = src;
   assign flush  = rs_valid & (src != PCSRC_SEQ) & ~stall;

`ifdef PC_SEQ_RAS_EN
   logic            ras_push;
   logic            ras_pop;
   logic [PC_W-1:0] ras_top;

   assign ras_push = ~stall & (src == PCSRC_JMP) & (func == FUNC_W'(FUNC_CALL));
   assign ras_pop  = ~stall & (src == PCSRC_REG);
   // An empty stack falls back to the register operand (plain JR or underflowed RET).
   assign reg_pc   = ras_empty ? reg_target : ras_top;

   pc_ras #(
      .W     (PC_W),
      .DEPTH (RAS_DEPTH)
   ) u_ras (
      .clk      (clk),
      .reset    (reset),
      .push     (ras_push),
      .pop      (ras_pop),
      .push_dat (rs_pc + PC_W'(1)),
      .top      (ras_top),
      .empty    (ras_empty),
      .full     (ras_full),
      .err      (ras_err)
   );
`else
   logic unused_ras;

   assign reg_pc     = reg_target;
   assign ras_empty  = 1'b1;
   assign ras_full   = 1'b0;
   assign ras_err    = 2'b00;
   assign unused_ras = &{1'b0, rs_pc, (RAS_DEPTH > 1)};
`endif

   always_comb begin
      pc_nxt = pc_out + PC_W'(1);
      case (src)
         PCSRC_JMP: pc_nxt = jump_target;
         PCSRC_BR:  pc_nxt = branch_target;
         PCSRC_REG: pc_nxt = reg_pc;
         default:   pc_nxt = pc_out + PC_W'(1);
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)
         pc_out <= RESET_PC;
      else if (!stall)
         pc_out <= pc_nxt;
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: each vector drives one cycle of inputs and queues the outputs
// expected in that cycle; a negedge monitor pops and compares. RAS section follows PC_SEQ_RAS_EN.
module tb_pc_sequencer;

   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_BEQ  = 4'h6;
   localparam logic [3:0] OP_BNE  = 4'h7;
   localparam logic [3:0] OP_JT   = 4'h8;
   localparam logic [2:0] FN_J    = 3'b000;
   localparam logic [2:0] FN_CALL = 3'b001;
   localparam logic [2:0] FN_RET  = 3'b010;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        stall = 1'b1;
   logic        rs_valid = 1'b0;
   logic [3:0]  op = '0;
   logic [2:0]  func = '0;
   logic        zero = 1'b0;
   logic [15:0] rs_pc = '0;
   logic [15:0] branch_target = '0;
   logic [15:0] jump_target = '0;
   logic [15:0] reg_target = '0;
   logic [15:0] pc_out;
   logic [1:0]  pc_src;
   logic        flush;
   logic        ras_empty;
   logic        ras_full;
   logic [1:0]  ras_err;

   typedef struct {
      string       nm;
      logic [15:0] pc;
      logic [1:0]  src;
      logic        fl;
      logic        emp;
      logic        full;
      logic [1:0]  err;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   nvec = 0;
   int   miscompares = 0;

   always #5 clk = ~clk;

   pc_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .stall         (stall),
      .rs_valid      (rs_valid),
      .op            (op),
      .func          (func),
      .zero          (zero),
      .rs_pc         (rs_pc),
      .branch_target (branch_target),
      .jump_target   (jump_target),
      .reg_target    (reg_target),
      .pc_out        (pc_out),
      .pc_src        (pc_src),
      .flush         (flush),
      .ras_empty     (ras_empty),
      .ras_full      (ras_full),
      .ras_err       (ras_err)
   );

   task automatic vec(input string nm, input logic rst, input logic st, input logic v,
                      input logic [3:0] o, input logic [2:0] f, input logic z,
                      input logic [15:0] rpc, input logic [15:0] bt, input logic [15:0] jt,
                      input logic [15:0] rt, input logic [15:0] e_pc, input logic [1:0] e_src,
                      input logic e_fl, input logic e_emp, input logic e_full, input logic [1:0] e_err);
      exp_t e;
      @(posedge clk);
      #1;
      reset = rst; stall = st; rs_valid = v; op = o; func = f; zero = z;
      rs_pc = rpc; branch_target = bt; jump_target = jt; reg_target = rt;
      e.nm = nm; e.pc = e_pc; e.src = e_src; e.fl = e_fl;
      e.emp = e_emp; e.full = e_full; e.err = e_err;
      sb.push_back(e);
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (sb.size() != 0) begin
            cur = sb.pop_front();
            nvec++;
            if ({pc_out, pc_src, flush, ras_empty, ras_full, ras_err} !==
                {cur.pc, cur.src, cur.fl, cur.emp, cur.full, cur.err}) begin
               miscompares++;
               $display("FAIL %s: got pc=%h src=%b flush=%b empty=%b full=%b err=%b, want pc=%h src=%b flush=%b empty=%b full=%b err=%b",
                        cur.nm, pc_out, pc_src, flush, ras_empty, ras_full, ras_err,
                        cur.pc, cur.src, cur.fl, cur.emp, cur.full, cur.err);
            end
         end
      end
   end

   initial begin
      //   name          rst st v  op       fn       z  rs_pc    br_tgt   jmp_tgt  reg_tgt  | pc       src    fl emp full err
      vec("rst_stall",   1, 1, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 2'b00, 0, 1, 0, 2'b00);
      vec("rst_release", 0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 2'b00, 0, 1, 0, 2'b00);
      vec("idle_1",      0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0001, 2'b00, 0, 1, 0, 2'b00);
      vec("idle_2",      0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0002, 2'b00, 0, 1, 0, 2'b00);
      vec("idle_3",      0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0003, 2'b00, 0, 1, 0, 2'b00);
      vec("beq_taken",   0, 0, 1, OP_BEQ,  FN_J,    1, 16'h0,   16'h40,  16'h0,   16'h0,   16'h0004, 2'b10, 1, 1, 0, 2'b00);
      vec("beq_not",     0, 0, 1, OP_BEQ,  FN_J,    0, 16'h0,   16'h90,  16'h0,   16'h0,   16'h0040, 2'b00, 0, 1, 0, 2'b00);
      vec("bne_stall",   0, 1, 1, OP_BNE,  FN_J,    0, 16'h0,   16'h60,  16'h0,   16'h0,   16'h0041, 2'b10, 0, 1, 0, 2'b00);
      vec("bne_release", 0, 0, 1, OP_BNE,  FN_J,    0, 16'h0,   16'h60,  16'h0,   16'h0,   16'h0041, 2'b10, 1, 1, 0, 2'b00);
      vec("bne_not",     0, 0, 1, OP_BNE,  FN_J,    1, 16'h0,   16'h99,  16'h0,   16'h0,   16'h0060, 2'b00, 0, 1, 0, 2'b00);
      vec("addi_seq",    0, 0, 1, OP_ADDI, FN_RET,  1, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0061, 2'b00, 0, 1, 0, 2'b00);
      vec("jump",        0, 0, 1, OP_JT,   FN_J,    0, 16'h0,   16'h0,   16'h200, 16'h0,   16'h0062, 2'b01, 1, 1, 0, 2'b00);
      vec("stall_idle",  0, 1, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0200, 2'b00, 0, 1, 0, 2'b00);
      vec("jump_ffff",   0, 0, 1, OP_JT,   FN_J,    0, 16'h0,   16'h0,   16'hFFFF,16'h0,   16'h0200, 2'b01, 1, 1, 0, 2'b00);
      vec("at_ffff",     0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'hFFFF, 2'b00, 0, 1, 0, 2'b00);
      vec("wrapped",     0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 2'b00, 0, 1, 0, 2'b00);
      vec("invalid_beq", 0, 0, 0, OP_BEQ,  FN_J,    1, 16'h0,   16'h77,  16'h0,   16'h0,   16'h0001, 2'b00, 0, 1, 0, 2'b00);
`ifdef PC_SEQ_RAS_EN
      vec("call",        0, 0, 1, OP_JT,   FN_CALL, 0, 16'h10,  16'h0,   16'h80,  16'h0,   16'h0002, 2'b01, 1, 1, 0, 2'b00);
      vec("ret",         0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h777, 16'h0080, 2'b11, 1, 0, 0, 2'b00);
      vec("after_ret",   0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0011, 2'b00, 0, 1, 0, 2'b00);
      vec("call_1",      0, 0, 1, OP_JT,   FN_CALL, 0, 16'h20,  16'h0,   16'hA0,  16'h0,   16'h0012, 2'b01, 1, 1, 0, 2'b00);
      vec("call_2",      0, 0, 1, OP_JT,   FN_CALL, 0, 16'h30,  16'h0,   16'hA1,  16'h0,   16'h00A0, 2'b01, 1, 0, 0, 2'b00);
      vec("call_3",      0, 0, 1, OP_JT,   FN_CALL, 0, 16'h40,  16'h0,   16'hA2,  16'h0,   16'h00A1, 2'b01, 1, 0, 0, 2'b00);
      vec("call_4",      0, 0, 1, OP_JT,   FN_CALL, 0, 16'h50,  16'h0,   16'hA3,  16'h0,   16'h00A2, 2'b01, 1, 0, 0, 2'b00);
      vec("call_5_ovf",  0, 0, 1, OP_JT,   FN_CALL, 0, 16'h60,  16'h0,   16'hA4,  16'h0,   16'h00A3, 2'b01, 1, 0, 1, 2'b00);
      vec("ret_1",       0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h700, 16'h00A4, 2'b11, 1, 0, 1, 2'b10);
      vec("ret_2",       0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h700, 16'h0061, 2'b11, 1, 0, 0, 2'b10);
      vec("ret_3",       0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h700, 16'h0051, 2'b11, 1, 0, 0, 2'b10);
      vec("ret_4",       0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h700, 16'h0041, 2'b11, 1, 0, 0, 2'b10);
      vec("ret_5_unf",   0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h700, 16'h0031, 2'b11, 1, 1, 0, 2'b10);
      vec("err_sticky",  0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0700, 2'b00, 0, 1, 0, 2'b11);
      vec("call_stall",  0, 1, 1, OP_JT,   FN_CALL, 0, 16'h5,   16'h0,   16'h900, 16'h0,   16'h0701, 2'b01, 0, 1, 0, 2'b11);
      vec("no_push",     0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0701, 2'b00, 0, 1, 0, 2'b11);
      vec("rst_again",   1, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0702, 2'b00, 0, 1, 0, 2'b11);
      vec("err_cleared", 0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 2'b00, 0, 1, 0, 2'b00);
`else
      vec("ret_noras",   0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h123, 16'h0002, 2'b11, 1, 1, 0, 2'b00);
      vec("call_noras",  0, 0, 1, OP_JT,   FN_CALL, 0, 16'h10,  16'h0,   16'h300, 16'h0,   16'h0123, 2'b01, 1, 1, 0, 2'b00);
      vec("ret2_noras",  0, 0, 1, OP_JT,   FN_RET,  0, 16'h0,   16'h0,   16'h0,   16'h55,  16'h0300, 2'b11, 1, 1, 0, 2'b00);
      vec("after_ret",   0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0055, 2'b00, 0, 1, 0, 2'b00);
      vec("rst_again",   1, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0056, 2'b00, 0, 1, 0, 2'b00);
      vec("post_rst",    0, 0, 0, 4'h0,    FN_J,    0, 16'h0,   16'h0,   16'h0,   16'h0,   16'h0000, 2'b00, 0, 1, 0, 2'b00);
`endif
      for (int i = 0; i < 5 && sb.size() != 0; i++)
         @(negedge clk);
      #1;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expected entries never checked, want 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
      $finish;
   end

endmodule
